// File: rtl/mips_ctrl_pkg.sv
// Shared control constants for the phase sequencer.
// Holds the FSM state encoding and the default opcode values.
package mips_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_t;

    localparam int unsigned OPC_W_DEF    = 5;
    localparam logic [4:0]  OP_HLT_DEF   = 5'b10001;
    localparam logic [4:0]  OP_LD_DEF    = 5'b10100;
    localparam logic [4:0]  JMP_MASK_DEF = 5'b11100;
    localparam logic [4:0]  JMP_VAL_DEF  = 5'b11100;

    localparam int unsigned STALL_W = 4;
    localparam int unsigned CNT_W   = 16;

endpackage

// File: rtl/phase_op_decode.sv
// Combinational opcode classifier for the phase sequencer.
// Ports: op (in) -> is_hlt, is_ld, is_jmp flags and stall_len bubble count.
module phase_op_decode
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W     = OPC_W_DEF,
    parameter logic [OPC_W-1:0] OP_HLT   = OP_HLT_DEF,
    parameter logic [OPC_W-1:0] OP_LD    = OP_LD_DEF,
    parameter logic [OPC_W-1:0] JMP_MASK = JMP_MASK_DEF,
    parameter logic [OPC_W-1:0] JMP_VAL  = JMP_VAL_DEF,
    parameter int unsigned LD_STALL  = 1,
    parameter int unsigned JMP_STALL = 2
) (
    input  logic [OPC_W-1:0]   op,
    output logic               is_hlt,
    output logic               is_ld,
    output logic               is_jmp,
    output logic [STALL_W-1:0] stall_len
);

    logic hit_hlt;
    logic hit_ld;
    logic hit_jmp;

    assign hit_hlt = (op == OP_HLT);
    assign hit_ld  = (op == OP_LD);
    assign hit_jmp = ((op & JMP_MASK) == JMP_VAL);

    // Priority: halt beats load beats jump.
    assign is_hlt = hit_hlt;
    assign is_ld  = hit_ld && !hit_hlt;
    assign is_jmp = hit_jmp && !hit_ld && !hit_hlt;

    always_comb begin
        stall_len = '0;
        if (is_ld) begin
            stall_len = STALL_W'(LD_STALL);
        end else if (is_jmp) begin
            stall_len = STALL_W'(JMP_STALL);
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// One-hot instruction phase sequencer with load/jump bubbles and halt.
// Ports: Clk, Rst (async high), Ins_op, Resume in; Phase_en, Instr_done,
// Stalled, Halted, Instr_cnt out (all from registered state).
module phase_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PHASES = 5,
    parameter int unsigned OPC_W      = OPC_W_DEF,
    parameter logic [OPC_W-1:0] OP_HLT   = OP_HLT_DEF,
    parameter logic [OPC_W-1:0] OP_LD    = OP_LD_DEF,
    parameter logic [OPC_W-1:0] JMP_MASK = JMP_MASK_DEF,
    parameter logic [OPC_W-1:0] JMP_VAL  = JMP_VAL_DEF,
    parameter int unsigned LD_STALL   = 1,
    parameter int unsigned JMP_STALL  = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [OPC_W-1:0]      Ins_op,
    input  logic                  Resume,
    output logic [NUM_PHASES-1:0] Phase_en,
    output logic                  Instr_done,
    output logic                  Stalled,
    output logic                  Halted,
    output logic [CNT_W-1:0]      Instr_cnt
);

    localparam logic [NUM_PHASES-1:0] PH_FIRST = NUM_PHASES'(1);

    seq_state_t            state_q, state_d;
    logic [NUM_PHASES-1:0] phase_q, phase_d;
    logic [STALL_W-1:0]    stall_q, stall_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic               is_hlt;
    logic               is_ld;
    logic               is_jmp;
    logic [STALL_W-1:0] stall_len;
    logic               bubble;
    logic               last;

    phase_op_decode #(
        .OPC_W     (OPC_W),
        .OP_HLT    (OP_HLT),
        .OP_LD     (OP_LD),
        .JMP_MASK  (JMP_MASK),
        .JMP_VAL   (JMP_VAL),
        .LD_STALL  (LD_STALL),
        .JMP_STALL (JMP_STALL)
    ) u_dec (
        .op        (Ins_op),
        .is_hlt    (is_hlt),
        .is_ld     (is_ld),
        .is_jmp    (is_jmp),
        .stall_len (stall_len)
    );

    // A zero-length stall behaves as a plain instruction.
    assign bubble = (is_ld || is_jmp) && (stall_len != '0);
    assign last   = phase_q[NUM_PHASES-1];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_STALL;
            phase_q <= '0;
            stall_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            stall_q <= stall_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        stall_d = stall_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (last) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_hlt) begin
                        state_d = ST_HALT;
                        phase_d = '0;
                    end else if (bubble) begin
                        state_d = ST_STALL;
                        stall_d = stall_len;
                        phase_d = '0;
                    end else begin
                        phase_d = PH_FIRST;
                    end
                end else if (phase_q == '0) begin
                    // Recover an empty ring rather than idle forever.
                    phase_d = PH_FIRST;
                end else begin
                    phase_d = phase_q << 1;
                end
            end
            ST_STALL: begin
                // Count 0 only occurs straight out of reset.
                if (stall_q <= STALL_W'(1)) begin
                    state_d = ST_RUN;
                    stall_d = '0;
                    phase_d = PH_FIRST;
                end else begin
                    stall_d = stall_q - STALL_W'(1);
                end
            end
            ST_HALT: begin
                if (Resume) begin
                    state_d = ST_RUN;
                    phase_d = PH_FIRST;
                end
            end
            default: begin
                state_d = ST_STALL;
                stall_d = '0;
                phase_d = '0;
            end
        endcase
    end

    assign Phase_en   = phase_q;
    assign Instr_done = phase_q[NUM_PHASES-1];
    assign Stalled    = (state_q == ST_STALL);
    assign Halted     = (state_q == ST_HALT);
    assign Instr_cnt  = cnt_q;

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter NUM_PHASES, default 5, is the number of one-hot execution phases per instruction; legal range 2..16.
REQ-002 Parameter OPC_W, default 5, is the opcode field width.
REQ-003 Parameters OP_HLT / OP_LD, defaults 5'b10001 / 5'b10100, are the exact-match halt and load opcodes.
REQ-004 Parameters JMP_MASK / JMP_VAL, defaults 5'b11100 / 5'b11100, define a jump as (Ins_op & JMP_MASK) == JMP_VAL.
REQ-005 Parameters LD_STALL / JMP_STALL, defaults 1 / 2, are the bubble cycles inserted after load / jump; legal range 0..15.
REQ-006 Clk  input  1  single system clock, all state on rising edge.
REQ-007 Rst  input  1  asynchronous, active-high reset.
REQ-008 Ins_op  input  OPC_W  opcode of the current instruction, stable throughout its phases.
REQ-009 Resume  input  1  one-cycle pulse that releases the halted state.
REQ-010 Phase_en  output  NUM_PHASES  one-hot phase enable (clock-enable to datapath stages, never a gated clock); all-zero during bubbles/halt.
REQ-011 Instr_done  output  1  high while Phase_en[NUM_PHASES-1] is high.
REQ-012 Stalled  output  1  high while in STALL state.
REQ-013 Halted  output  1  high while in HALT state.
REQ-014 Instr_cnt  output  16  count of completed instructions, wraps 16'hFFFF -> 0.

Function
REQ-015 FSM states: RUN, STALL, HALT; all outputs are registered or decoded from registered state only.
REQ-016 RUN: Phase_en shifts left by one position each rising edge; Phase_en never has more than one bit set.
REQ-017 On the edge ending the last phase, Ins_op is decoded with priority HLT > LD > JMP > other, and Instr_cnt increments by 1.
REQ-018 Other opcode: Phase_en wraps to bit 0 with no gap.
REQ-019 LD/JMP with stall N>0: enter STALL, load stall counter with N, Phase_en = 0 for exactly N cycles, then RUN at bit 0.
REQ-020 LD/JMP with stall 0: behaves as REQ-018.
REQ-021 STALL: counter decrements each edge; on the edge where counter == 1 (or counter == 0 after reset), go to RUN with Phase_en = bit 0.
REQ-022 HLT: enter HALT, Phase_en = 0, remain until Resume sampled high; next edge returns to RUN with Phase_en = bit 0.
REQ-023 Resume is ignored outside HALT, including on the edge at which HLT is decoded.
REQ-024 Ins_op is ignored in all phases except the last, and in STALL/HALT.
REQ-025 Stall counter width is 4 bits; Instr_cnt is unchanged in STALL and HALT.

Reset
REQ-026 Rst high forces immediately: state STALL, stall counter 0, Phase_en 0, Stalled 1, Halted 0, Instr_done 0, Instr_cnt 0.
REQ-027 First rising edge after Rst deassertion yields RUN with Phase_en = bit 0; reset mid-instruction abandons it without incrementing Instr_cnt.

Structure
REQ-028 State encoding enum and default opcode constants reside in shared package mips_ctrl_pkg.
REQ-029 Opcode decode (HLT/LD/JMP flags and selected stall length) is one combinational sub-module, phase_op_decode; the FSM, ring and counters stay in phase_sequencer.

Verification (defaults unless stated)
REQ-030 Rst pulse, Ins_op = 0 -> Phase_en 00000, then 00001,00010,00100,01000,10000,00001; Instr_cnt = 1 after first wrap.
REQ-031 Ins_op = 10100 during phase 4 -> one cycle Phase_en = 00000 with Stalled = 1, then 00001.
REQ-032 Ins_op = 11101 during phase 4 -> two cycles Phase_en = 00000, then 00001; Instr_cnt +1 only.
REQ-033 Ins_op = 10001 during phase 4, Resume after 10 cycles -> Halted = 1, Phase_en = 0, Instr_cnt frozen; Phase_en = 00001 on the edge after Resume.
REQ-034 Rst asserted asynchronously during phase 2 -> Phase_en = 0 and Instr_cnt = 0 before the next edge; Resume pulsed in RUN has no effect.
REQ-035 NUM_PHASES = 3, LD_STALL = 0, Ins_op = 10100 -> Phase_en 001,010,100,001 with no bubble.
